// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and constants for the sequential multiply/divide unit
package mdu_pkg;
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MUL_LO  = 3'd1,
    S_MUL_HI  = 3'd2,
    S_DIV_RUN = 3'd3,
    S_DIV_FIX = 3'd4
  } state_t;
  localparam logic [3:0] ALU_MULT_LO = 4'b1010;
  localparam logic [3:0] ALU_MULT_HI = 4'b1011;
  localparam logic [3:0] ALU_NOP     = 4'b0000;
  localparam int DIV_ITER = 32;
endpackage

// File: rtl/mdu_divider.sv
// mdu_divider: 32-step restoring divider on unsigned magnitudes
module mdu_divider
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quo,
  output logic [31:0] rem,
  output logic        valid
);
  logic        run;
  logic [5:0]  cnt;
  logic [31:0] d;
  logic [32:0] sh;
  logic [32:0] diff;
  assign sh    = {rem, quo[31]};
  assign diff  = sh - {1'b0, d};
  // valid marks the final iteration; quo/rem hold the result from the following cycle
  assign valid = run && cnt == 6'(DIV_ITER - 1);
  // one shift/subtract step per cycle; the borrow bit decides each quotient bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run <= 1'b0;
      cnt <= '0;
      d   <= '0;
      quo <= '0;
      rem <= '0;
    end else if (start) begin
      run <= 1'b1;
      cnt <= '0;
      d   <= divisor;
      quo <= dividend;
      rem <= '0;
    end else if (run) begin
      quo <= {quo[30:0], ~diff[32]};
      rem <= diff[32] ? sh[31:0] : diff[31:0];
      cnt <= cnt + 6'd1;
      run <= !valid;
    end
  end
endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: sequential MULT/MULTU/DIV/DIVU unit with HI/LO; divider present only with MDU_DIV_EN
module mdu_seq
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_ctrl,
  input  logic [31:0] alu_out,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);
  state_t      state;
  op_t         op_r;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic [31:0] lo_tmp;
  logic        mul;
  logic [31:0] hi_mul;
  // the external ALU only sees operands while a multiply is in progress
  always_comb begin
    mul      = state == S_MUL_LO || state == S_MUL_HI;
    alu_a    = mul ? a_r : '0;
    alu_b    = mul ? b_r : '0;
    alu_ctrl = state == S_MUL_LO ? ALU_MULT_LO : state == S_MUL_HI ? ALU_MULT_HI : ALU_NOP;
    busy     = state != S_IDLE;
    hi_mul   = op_r == OP_MULTU ? alu_out + (a_r[31] ? b_r : '0) + (b_r[31] ? a_r : '0) : alu_out;
  end
`ifdef MDU_DIV_EN
  logic [31:0] div_quo;
  logic [31:0] div_rem;
  logic        div_valid;
  logic        div_start;
  logic        dsgn;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] lo_fix;
  logic [31:0] hi_fix;
  // magnitudes feed the divider at start; signs are restored from the captured operands
  always_comb begin
    div_start = state == S_IDLE && start && op[1];
    a_mag     = (!op[0] && rs_val[31]) ? -rs_val : rs_val;
    b_mag     = (!op[0] && rt_val[31]) ? -rt_val : rt_val;
    dsgn      = op_r == OP_DIV;
    lo_fix    = b_r == '0 ? '1 : (dsgn && (a_r[31] ^ b_r[31])) ? -div_quo : div_quo;
    hi_fix    = b_r == '0 ? a_r : (dsgn && a_r[31]) ? -div_rem : div_rem;
  end
  mdu_divider u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (a_mag),
    .divisor  (b_mag),
    .quo      (div_quo),
    .rem      (div_rem),
    .valid    (div_valid)
  );
`endif
  // control FSM, HI/LO commit and the one-cycle done pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      op_r   <= OP_MULT;
      a_r    <= '0;
      b_r    <= '0;
      lo_tmp <= '0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            op_r <= op_t'(op);
            a_r  <= rs_val;
            b_r  <= rt_val;
`ifdef MDU_DIV_EN
            state <= op[1] ? S_DIV_RUN : S_MUL_LO;
`else
            state <= op[1] ? S_IDLE : S_MUL_LO;
            done  <= op[1];
`endif
          end
        end
        S_MUL_LO: begin
          lo_tmp <= alu_out;
          state  <= S_MUL_HI;
        end
        S_MUL_HI: begin
          hi    <= hi_mul;
          lo    <= lo_tmp;
          done  <= 1'b1;
          state <= S_IDLE;
        end
`ifdef MDU_DIV_EN
        S_DIV_RUN: if (div_valid) state <= S_DIV_FIX;
        S_DIV_FIX: begin
          hi    <= hi_fix;
          lo    <= lo_fix;
          done  <= 1'b1;
          state <= S_IDLE;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: randomized self-checking bench for mdu_seq with a behavioural ALU and HI/LO reference
module tb_mdu_seq;
  import mdu_pkg::*;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] alu_a, alu_b, alu_out, hi, lo;
  logic [3:0]  alu_ctrl;
  logic        busy, done;
  logic signed [63:0] prod;
  logic [3:0]  c0, c1;
  int tests = 0;
  int fails = 0;

  mdu_seq dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .alu_a(alu_a), .alu_b(alu_b),
    .alu_ctrl(alu_ctrl), .alu_out(alu_out), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // shared ALU: signed 32x32 product, low or high word
  always_comb begin
    prod    = $signed({{32{alu_a[31]}}, alu_a}) * $signed({{32{alu_b[31]}}, alu_b});
    alu_out = alu_ctrl == ALU_MULT_LO ? prod[31:0] : alu_ctrl == ALU_MULT_HI ? prod[63:32] : 32'h0;
  end

  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a, b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (o == 2'b00) return 64'(sa * sb);
    if (o == 2'b01) return {32'h0, a} * {32'h0, b};
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    if (o == 2'b11) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    return {32'(sa % sb), 32'(sa / sb)};
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, b, input int inj_k, input int inj_kind,
                        output logic [31:0] rhi, rlo, output int lat, output int bcnt);
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1; bcnt = 0; rhi = '0; rlo = '0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (k == 0) c0 = alu_ctrl;
      if (k == 1) c1 = alu_ctrl;
      if (done) begin lat = k; rhi = hi; rlo = lo; break; end
      if (busy) bcnt++;
      if (k == inj_k && inj_kind == 1) begin start = 1'b1; op = OP_MULT; rs_val = 3; rt_val = 3; end
      if (k == inj_k && inj_kind == 2) begin hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5555; end
      @(posedge clk);
      #1 start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    end
    tests++;
    if (lat < 0) begin fails++; $display("FAIL timeout op=%0d: no done within 60 cycles", o); end
    @(negedge clk);
    tests++;
    if (done !== 1'b0) begin fails++; $display("FAIL done_width: done=%b required 0", done); end
  endtask

  task automatic check_op(input string name, input logic [1:0] o, input logic [31:0] a, b, input int exp_lat);
    logic [31:0] rh, rl;
    logic [63:0] e;
    int lat, bc;
    e = ref_model(o, a, b);
    run_op(o, a, b, -1, 0, rh, rl, lat, bc);
    tests++;
    if ({rh, rl} !== e) begin
      fails++;
      $display("FAIL %s op=%0d a=%h b=%h: got hi=%h lo=%h required hi=%h lo=%h", name, o, a, b, rh, rl, e[63:32], e[31:0]);
    end
    tests++;
    if (lat !== exp_lat) begin fails++; $display("FAIL %s_latency: got %0d required %0d", name, lat, exp_lat); end
  endtask

  task automatic mt_write(input logic h, input logic [31:0] v);
    @(negedge clk);
    hi_we = h; lo_we = !h; wdata = v;
    @(posedge clk);
    #1 hi_we = 1'b0; lo_we = 1'b0;
    @(negedge clk);
    tests++;
    if ((h ? hi : lo) !== v) begin fails++; $display("FAIL mt_write h=%0b: got %h required %h", h, h ? hi : lo, v); end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    tests++;
    if ({hi, lo, busy, done, alu_a, alu_b, alu_ctrl} !== '0) begin
      fails++;
      $display("FAIL reset: hi=%h lo=%h busy=%b done=%b alu_a=%h alu_b=%h ctrl=%h required all 0", hi, lo, busy, done, alu_a, alu_b, alu_ctrl);
    end
    reset = 1'b0;
  endtask

  task automatic test_mult_basic;
    logic [31:0] rh, rl;
    int lat, bc;
    run_op(OP_MULT, 5, 4, -1, 0, rh, rl, lat, bc);
    tests++;
    if (rl !== 32'd20 || rh !== 32'd0) begin fails++; $display("FAIL mult_5x4: got hi=%h lo=%h required 0/14", rh, rl); end
    tests++;
    if (lat !== 2) begin fails++; $display("FAIL mult_latency: got %0d required 2", lat); end
    tests++;
    if (bc !== 2) begin fails++; $display("FAIL mult_busy: got %0d cycles required 2", bc); end
    tests++;
    if (c0 !== 4'b1010 || c1 !== 4'b1011) begin fails++; $display("FAIL alu_ctrl: got %b,%b required 1010,1011", c0, c1); end
  endtask

  task automatic test_mult_corners;
    logic [31:0] rh, rl;
    int lat, bc;
    for (int i = 0; i < 2; i++) begin
      run_op(2'(i), 32'd2111222333, 32'd2111222333, -1, 0, rh, rl, lat, bc);
      tests++;
      if ({rh, rl} !== 64'd4457259739357962889) begin fails++; $display("FAIL mult_big op=%0d: got %h_%h required 64'd4457259739357962889", i, rh, rl); end
    end
    run_op(OP_MULT, 32'hFFFF_FFFF, 2, -1, 0, rh, rl, lat, bc);
    tests++;
    if (rh !== 32'hFFFF_FFFF || rl !== 32'hFFFF_FFFE) begin fails++; $display("FAIL mult_neg1x2: got hi=%h lo=%h required ffffffff/fffffffe", rh, rl); end
    run_op(OP_MULTU, 32'hFFFF_FFFF, 2, -1, 0, rh, rl, lat, bc);
    tests++;
    if (rh !== 32'h1 || rl !== 32'hFFFF_FFFE) begin fails++; $display("FAIL multu_maxx2: got hi=%h lo=%h required 1/fffffffe", rh, rl); end
  endtask

  task automatic test_mult_random;
    logic [31:0] a, b;
    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 5 == 0) a = 32'h8000_0000;
      if (i % 7 == 1) b = 32'hFFFF_FFFF;
      check_op("mult_rand", 2'($urandom_range(0, 1)), a, b, 2);
    end
  endtask

  task automatic test_div;
`ifdef MDU_DIV_EN
    logic [31:0] a, b;
    check_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 2, 33);
    tests++;
    if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin fails++; $display("FAIL div_m7_2_const: got hi=%h lo=%h required ffffffff/fffffffd", hi, lo); end
    check_op("divu_7_0", OP_DIVU, 7, 0, 33);
    tests++;
    if (lo !== 32'hFFFF_FFFF || hi !== 32'd7) begin fails++; $display("FAIL divu_7_0_const: got hi=%h lo=%h required 7/ffffffff", hi, lo); end
    check_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33);
    tests++;
    if (lo !== 32'h8000_0000 || hi !== 32'h0) begin fails++; $display("FAIL div_ovf_const: got hi=%h lo=%h required 0/80000000", hi, lo); end
    check_op("div_by0_signed", OP_DIV, 32'hFFFF_FF00, 0, 33);
    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if (i % 4 == 1) b = -b;
      check_op("div_rand", 2'($urandom_range(2, 3)), a, b, 33);
    end
`else
    logic [31:0] rh, rl;
    int lat, bc;
    mt_write(1'b1, 32'hCAFE_0001);
    mt_write(1'b0, 32'hCAFE_0002);
    for (int i = 2; i < 4; i++) begin
      run_op(2'(i), 32'd100, 32'd7, -1, 0, rh, rl, lat, bc);
      tests++;
      if (lat !== 0 || bc !== 0) begin fails++; $display("FAIL div_disabled_timing op=%0d: lat=%0d busy=%0d required 0/0", i, lat, bc); end
      tests++;
      if (rh !== 32'hCAFE_0001 || rl !== 32'hCAFE_0002) begin fails++; $display("FAIL div_disabled_hilo: got %h/%h required cafe0001/cafe0002", rh, rl); end
    end
`endif
  endtask

  task automatic test_ignore;
    logic [31:0] rh, rl;
    int lat, bc;
    run_op(OP_MULT, 6, 7, 1, 2, rh, rl, lat, bc);
    tests++;
    if (rh !== 32'd0 || rl !== 32'd42 || lat !== 2) begin fails++; $display("FAIL ignore_mthi: got hi=%h lo=%h lat=%0d required 0/2a/2", rh, rl, lat); end
`ifdef MDU_DIV_EN
    run_op(OP_DIV, 100, 7, 5, 1, rh, rl, lat, bc);
    tests++;
    if (rh !== 32'd2 || rl !== 32'd14 || lat !== 33) begin fails++; $display("FAIL ignore_start: got hi=%h lo=%h lat=%0d required 2/e/33", rh, rl, lat); end
`else
    run_op(OP_MULT, 6, 7, 0, 1, rh, rl, lat, bc);
    tests++;
    if (rh !== 32'd0 || rl !== 32'd42 || lat !== 2) begin fails++; $display("FAIL ignore_start: got hi=%h lo=%h lat=%0d required 0/2a/2", rh, rl, lat); end
`endif
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL ignore_start_busy: busy=%b required 0", busy); end
  endtask

  task automatic test_write_coincide;
    int seen = 0;
    @(negedge clk);
    start = 1'b1; op = OP_MULT; rs_val = 3; rt_val = 5; hi_we = 1'b1; wdata = 32'hAAAA;
    @(posedge clk);
    #1 start = 1'b0; hi_we = 1'b0;
    @(negedge clk);
    tests++;
    if (hi !== 32'hAAAA) begin fails++; $display("FAIL coincide_write: hi=%h required aaaa", hi); end
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = done;
    end
    tests++;
    if (!seen || hi !== 32'd0 || lo !== 32'd15) begin fails++; $display("FAIL coincide_commit: done=%0d hi=%h lo=%h required 1/0/f", seen, hi, lo); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rh, rl;
    int lat, bc;
    int spurious = 0;
    mt_write(1'b1, 32'h1234);
    mt_write(1'b0, 32'h5678);
    @(negedge clk);
`ifdef MDU_DIV_EN
    start = 1'b1; op = OP_DIV; rs_val = 1000; rt_val = 3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
`else
    start = 1'b1; op = OP_MULT; rs_val = 9; rt_val = 9;
    @(posedge clk);
    #1 start = 1'b0;
`endif
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if ({busy, done, hi, lo} !== '0) begin fails++; $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h required all 0", busy, done, hi, lo); end
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || busy) spurious++;
    end
    tests++;
    if (spurious !== 0) begin fails++; $display("FAIL reset_mid_quiet: %0d cycles with done/busy required 0", spurious); end
    run_op(OP_MULT, 4, 3, -1, 0, rh, rl, lat, bc);
    tests++;
    if (rl !== 32'd12 || rh !== 32'd0) begin fails++; $display("FAIL reset_mid_mult: got hi=%h lo=%h required 0/c", rh, rl); end
  endtask

  initial begin
    test_reset;
    test_mult_basic;
    test_mult_corners;
    test_mult_random;
    mt_write(1'b1, $urandom);
    mt_write(1'b0, $urandom);
    test_div;
    test_ignore;
    test_write_coincide;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
